// File: rtl/cpu_seq_pkg.sv
// +------------------------------------------------------------------+
// | cpu_seq_pkg : shared timing-state, interrupt-code and opcode      |
// | constants for the T-state sequencer.          Rev 1.0             |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_seq_pkg;

    typedef enum logic [6:0] {
        T0 = 7'b0000001,
        T1 = 7'b0000010,
        T2 = 7'b0000100,
        T3 = 7'b0001000,
        T4 = 7'b0010000,
        T5 = 7'b0100000,
        T6 = 7'b1000000
    } tstate_e;

    localparam logic [2:0] c_int_none = 3'b000;
    localparam logic [2:0] c_int_irq  = 3'b001;
    localparam logic [2:0] c_int_nmi  = 3'b010;
    localparam logic [2:0] c_int_rst  = 3'b100;

    localparam logic [7:0] c_op_brk   = 8'h00;

endpackage

`default_nettype wire

// File: rtl/int_pending.sv
// +------------------------------------------------------------------+
// | int_pending : NMI edge capture, IRQ qualification and RST>NMI>IRQ |
// | priority encode.                              Rev 1.0             |
// +------------------------------------------------------------------+
`default_nettype none

module int_pending
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_adv,
    input  logic       i_run,
    input  logic       i_take,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_flag,
    output logic       o_pend,
    output logic [2:0] o_code
);

    logic r_rst_pend;
    logic r_nmi_pend;
    logic r_nmi_cap;
    logic r_nmi_prev;
    logic w_nmi_edge;
    logic w_irq_req;

    assign w_nmi_edge = i_adv & r_nmi_prev & ~i_nmi_n;
    assign w_irq_req  = ~i_irq_n & ~i_flag;

    always_comb begin
        o_code = c_int_none;
        if (r_rst_pend) begin
            o_code = c_int_rst;
        end else if (r_nmi_pend) begin
            o_code = c_int_nmi;
        end else if (w_irq_req) begin
            o_code = c_int_irq;
        end
    end

    assign o_pend = (o_code != c_int_none);

    // An NMI edge seen while stalled is parked in r_nmi_cap so nmi_pend itself holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_pend <= 1'b1;
            r_nmi_pend <= 1'b0;
            r_nmi_cap  <= 1'b0;
            r_nmi_prev <= 1'b1;
        end else begin
            if (i_adv) begin
                r_nmi_prev <= i_nmi_n;
            end
            if (i_adv && i_run) begin
                if (i_take && (o_code == c_int_rst)) begin
                    r_rst_pend <= 1'b0;
                end
                r_nmi_pend <= (r_nmi_pend & ~(i_take & (o_code == c_int_nmi)))
                            | w_nmi_edge | r_nmi_cap;
                r_nmi_cap  <= 1'b0;
            end else if (w_nmi_edge) begin
                r_nmi_cap  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tstate_sequencer.sv
// +------------------------------------------------------------------+
// | tstate_sequencer : two-phase clock and one-hot T-state sequencer  |
// | with forced-BRK interrupt entry. Option: TSEQ_RDY_STALL_EN. Rev 1.0|
// +------------------------------------------------------------------+
`default_nettype none

module tstate_sequencer
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] opcode_in,
    input  logic       last_cycle,
    input  logic       rdy,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       i_flag,
    output logic       phi1,
    output logic       phi2,
    output logic [6:0] T,
    output logic [7:0] OP,
    output logic [7:0] prevOP,
    output logic [2:0] activeInt,
    output logic       sync,
    output logic       seq_err
);

    logic       r_phase;
    tstate_e    r_t;
    logic [7:0] r_op;
    logic [7:0] r_prev_op;
    logic [2:0] r_active_int;
    logic       r_seq_err;

    tstate_e    w_t_nxt;
    logic [7:0] w_op_nxt;
    logic [7:0] w_prev_nxt;
    logic [2:0] w_int_nxt;
    logic       w_err_nxt;
    logic       w_take;
    logic       w_run;
    logic       w_step;
    logic       w_pend;
    logic [2:0] w_code;

`ifdef TSEQ_RDY_STALL_EN
    assign w_run = rdy;
`else
    // rdy is ignored in this build; the OR only keeps the port read.
    assign w_run = rdy | 1'b1;
`endif

    assign w_step = r_phase & w_run;

    int_pending u_int_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (r_phase),
        .i_run   (w_run),
        .i_take  (w_take),
        .i_nmi_n (nmi_n),
        .i_irq_n (irq_n),
        .i_flag  (i_flag),
        .o_pend  (w_pend),
        .o_code  (w_code)
    );

    always_comb begin
        w_t_nxt    = r_t;
        w_op_nxt   = r_op;
        w_prev_nxt = r_prev_op;
        w_int_nxt  = r_active_int;
        w_err_nxt  = r_seq_err;
        w_take     = 1'b0;
        if (w_step) begin
            if (last_cycle) begin
                w_t_nxt    = T1;
                w_prev_nxt = r_op;
                w_int_nxt  = c_int_none;
            end else begin
                case (r_t)
                    T1: begin
                        w_t_nxt   = T2;
                        w_take    = 1'b1;
                        w_op_nxt  = w_pend ? c_op_brk : opcode_in;
                        w_int_nxt = w_code;
                    end
                    T2:      w_t_nxt   = T3;
                    T3:      w_t_nxt   = T4;
                    T4:      w_t_nxt   = T5;
                    T5:      w_t_nxt   = T6;
                    T6:      w_err_nxt = 1'b1;
                    default: w_t_nxt   = T1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= 1'b0;
            r_t          <= T1;
            r_op         <= c_op_brk;
            r_prev_op    <= c_op_brk;
            r_active_int <= c_int_rst;
            r_seq_err    <= 1'b0;
        end else begin
            r_phase      <= ~r_phase;
            r_t          <= w_t_nxt;
            r_op         <= w_op_nxt;
            r_prev_op    <= w_prev_nxt;
            r_active_int <= w_int_nxt;
            r_seq_err    <= w_err_nxt;
        end
    end

    assign phi1      = ~r_phase;
    assign phi2      = r_phase;
    assign T         = r_t;
    assign OP        = r_op;
    assign prevOP    = r_prev_op;
    assign activeInt = r_active_int;
    assign sync      = (r_t == T1);
    assign seq_err   = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_tstate_sequencer.sv
// +------------------------------------------------------------------+
// | tb_tstate_sequencer : directed scoreboard bench for the T-state   |
// | sequencer. Honours TSEQ_RDY_STALL_EN.          Rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_tstate_sequencer;

    localparam logic [6:0] c_t1 = 7'b0000010;
    localparam logic [6:0] c_t2 = 7'b0000100;
    localparam logic [6:0] c_t3 = 7'b0001000;
    localparam logic [6:0] c_t4 = 7'b0010000;
    localparam logic [6:0] c_t5 = 7'b0100000;
    localparam logic [6:0] c_t6 = 7'b1000000;

    logic       clk;
    logic       rst_n;
    logic [7:0] opcode_in;
    logic       last_cycle;
    logic       rdy;
    logic       irq_n;
    logic       nmi_n;
    logic       i_flag;
    logic       phi1;
    logic       phi2;
    logic [6:0] T;
    logic [7:0] OP;
    logic [7:0] prevOP;
    logic [2:0] activeInt;
    logic       sync;
    logic       seq_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [6:0] t;
        logic [7:0] op;
        logic [7:0] prev;
        logic [2:0] ai;
        logic       err;
    } exp_t;

    exp_t sb[$];

    tstate_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode_in  (opcode_in),
        .last_cycle (last_cycle),
        .rdy        (rdy),
        .irq_n      (irq_n),
        .nmi_n      (nmi_n),
        .i_flag     (i_flag),
        .phi1       (phi1),
        .phi2       (phi2),
        .T          (T),
        .OP         (OP),
        .prevOP     (prevOP),
        .activeInt  (activeInt),
        .sync       (sync),
        .seq_err    (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [6:0] t, input logic [7:0] op,
                            input logic [7:0] prev, input logic [2:0] ai, input logic err);
        exp_t e;
        e.tag  = tag;
        e.t    = t;
        e.op   = op;
        e.prev = prev;
        e.ai   = ai;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".T"},         {1'b0, T},         {1'b0, e.t});
            chk({e.tag, ".OP"},        OP,                e.op);
            chk({e.tag, ".prevOP"},    prevOP,            e.prev);
            chk({e.tag, ".activeInt"}, {5'b0, activeInt}, {5'b0, e.ai});
            chk({e.tag, ".seq_err"},   {7'b0, seq_err},   {7'b0, e.err});
            chk({e.tag, ".sync"},      {7'b0, sync},      {7'b0, (e.t == c_t1)});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input string tag, input logic [6:0] t, input logic [7:0] op,
                       input logic [7:0] prev, input logic [2:0] ai, input logic err);
        push_exp(tag, t, op, prev, ai, err);
        cycle();
        compare_out();
    endtask

    initial begin
        rst_n      = 1'b0;
        opcode_in  = 8'hA9;
        last_cycle = 1'b0;
        rdy        = 1'b1;
        irq_n      = 1'b1;
        nmi_n      = 1'b1;
        i_flag     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        push_exp("reset", c_t1, 8'h00, 8'h00, 3'b100, 1'b0);
        compare_out();
        chk("reset.phi1", {7'b0, phi1}, 8'h01);
        chk("reset.phi2", {7'b0, phi2}, 8'h00);

        // First CPU cycle after release: forced BRK for the pending RST.
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("rst_brk", c_t2, 8'h00, 8'h00, 3'b100, 1'b0);
        @(posedge clk);
        #1;
        chk("phase_hi.phi2", {7'b0, phi2}, 8'h01);
        chk("phase_hi.phi1", {7'b0, phi1}, 8'h00);
        chk("phase_hi.T",    {1'b0, T},    {1'b0, c_t1});
        @(posedge clk);
        #1;
        compare_out();
        chk("phase_lo.phi2", {7'b0, phi2}, 8'h00);

        last_cycle = 1'b1;
        adv("rst_done",  c_t1, 8'h00, 8'h00, 3'b000, 1'b0);
        last_cycle = 1'b0;
        adv("lda_load",  c_t2, 8'hA9, 8'h00, 3'b000, 1'b0);
        last_cycle = 1'b1;
        adv("lda_ret",   c_t1, 8'hA9, 8'hA9, 3'b000, 1'b0);

        opcode_in  = 8'h4C;
        irq_n      = 1'b0;
        last_cycle = 1'b0;
        adv("irq_masked", c_t2, 8'h4C, 8'hA9, 3'b000, 1'b0);
        last_cycle = 1'b1;
        adv("jmp_ret",    c_t1, 8'h4C, 8'h4C, 3'b000, 1'b0);
        i_flag     = 1'b0;
        last_cycle = 1'b0;
        adv("irq_take",   c_t2, 8'h00, 8'h4C, 3'b001, 1'b0);
        last_cycle = 1'b1;
        adv("irq_done",   c_t1, 8'h00, 8'h00, 3'b000, 1'b0);

        last_cycle = 1'b0;
        adv("irq_again",  c_t2, 8'h00, 8'h00, 3'b001, 1'b0);
        adv("irq_t3",     c_t3, 8'h00, 8'h00, 3'b001, 1'b0);
        nmi_n = 1'b0;
        adv("nmi_edge",   c_t4, 8'h00, 8'h00, 3'b001, 1'b0);
        nmi_n      = 1'b1;
        last_cycle = 1'b1;
        adv("irq2_done",  c_t1, 8'h00, 8'h00, 3'b000, 1'b0);
        last_cycle = 1'b0;
        adv("nmi_wins",   c_t2, 8'h00, 8'h00, 3'b010, 1'b0);
        last_cycle = 1'b1;
        adv("nmi_done",   c_t1, 8'h00, 8'h00, 3'b000, 1'b0);
        last_cycle = 1'b0;
        adv("irq_after_nmi", c_t2, 8'h00, 8'h00, 3'b001, 1'b0);
        irq_n      = 1'b1;
        i_flag     = 1'b1;
        last_cycle = 1'b1;
        adv("irq3_done",  c_t1, 8'h00, 8'h00, 3'b000, 1'b0);

        opcode_in  = 8'hEA;
        last_cycle = 1'b0;
        adv("nop_load",   c_t2, 8'hEA, 8'h00, 3'b000, 1'b0);
        adv("nop_t3",     c_t3, 8'hEA, 8'h00, 3'b000, 1'b0);
        rdy = 1'b0;
`ifdef TSEQ_RDY_STALL_EN
        adv("stall1",     c_t3, 8'hEA, 8'h00, 3'b000, 1'b0);
        adv("stall2",     c_t3, 8'hEA, 8'h00, 3'b000, 1'b0);
        adv("stall3",     c_t3, 8'hEA, 8'h00, 3'b000, 1'b0);
`else
        adv("nostall1",   c_t4, 8'hEA, 8'h00, 3'b000, 1'b0);
        adv("nostall2",   c_t5, 8'hEA, 8'h00, 3'b000, 1'b0);
        adv("nostall3",   c_t6, 8'hEA, 8'h00, 3'b000, 1'b0);
`endif
        rdy        = 1'b1;
        last_cycle = 1'b1;
        adv("stall_end",  c_t1, 8'hEA, 8'hEA, 3'b000, 1'b0);

        opcode_in  = 8'h02;
        last_cycle = 1'b0;
        adv("ovf_t2",     c_t2, 8'h02, 8'hEA, 3'b000, 1'b0);
        adv("ovf_t3",     c_t3, 8'h02, 8'hEA, 3'b000, 1'b0);
        adv("ovf_t4",     c_t4, 8'h02, 8'hEA, 3'b000, 1'b0);
        adv("ovf_t5",     c_t5, 8'h02, 8'hEA, 3'b000, 1'b0);
        adv("ovf_t6",     c_t6, 8'h02, 8'hEA, 3'b000, 1'b0);
        adv("ovf_hold1",  c_t6, 8'h02, 8'hEA, 3'b000, 1'b1);
        adv("ovf_hold2",  c_t6, 8'h02, 8'hEA, 3'b000, 1'b1);
        last_cycle = 1'b1;
        adv("ovf_ret",    c_t1, 8'h02, 8'h02, 3'b000, 1'b1);
        opcode_in  = 8'hA9;
        last_cycle = 1'b0;
        adv("mid_t2",     c_t2, 8'hA9, 8'h02, 3'b000, 1'b1);

        // Reset asserted between clock edges, mid-instruction.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("mid_rst", c_t1, 8'h00, 8'h00, 3'b100, 1'b0);
        compare_out();
        @(negedge clk);
        rst_n = 1'b1;
        adv("rst_brk2",   c_t2, 8'h00, 8'h00, 3'b100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tstate_sequencer.md
TSTATE_SEQUENCER -- requirements
Module: tstate_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; every flop is rising-edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode_in, input, 8, data-bus byte, sampled as the opcode at the end of T1.
REQ-004 SHALL have port last_cycle, input, 1, from random logic: the current T is the final cycle of OP.
REQ-005 SHALL have port rdy, input, 1, ready; low stalls sequencing.
REQ-006 SHALL have ports irq_n and nmi_n, input, 1 each, interrupt request lines, active-low.
REQ-007 SHALL have port i_flag, input, 1, status I bit; 1 masks IRQ.
REQ-008 SHALL have ports phi1 and phi2, output, 1 each, non-overlapping phase strobes.
REQ-009 SHALL have port T, output, 7, one-hot timing state; bit n is Tn, T0..T6.
REQ-010 SHALL have ports OP and prevOP, output, 8 each, current and previous opcode.
REQ-011 SHALL have port activeInt, output, 3, one-hot interrupt code: 001 IRQ, 010 NMI, 100 RST, 000 none.
REQ-012 SHALL have port sync, output, 1, high throughout T1.
REQ-013 SHALL have port seq_err, output, 1, sticky T-overflow flag.

Function
REQ-014 phase SHALL toggle every clk: phi1=~phase, phi2=phase; one CPU cycle equals two clk.
REQ-015 T, OP, prevOP and activeInt SHALL update only on the clk edge that ends phi2 (the advance edge).
REQ-016 On the advance edge with last_cycle=1, the block SHALL set T to T1 and copy OP to prevOP.
REQ-017 On the advance edge in T1, the block SHALL set T to T2 and load OP.
REQ-018 In REQ-017, OP SHALL be loaded as 8'h00 (BRK) if an interrupt is pending; otherwise OP SHALL be loaded from opcode_in.
REQ-019 For T2..T5 with last_cycle=0, the advance edge SHALL move T to the next state.
REQ-020 At T6 with last_cycle=0, T SHALL hold and seq_err SHALL set.
REQ-021 last_cycle SHALL have priority over the increment in every state.
REQ-022 A falling edge of nmi_n, sampled on advance edges, SHALL set nmi_pend.
REQ-023 nmi_pend SHALL clear when the NMI sequence is taken.
REQ-024 The IRQ request SHALL be level-sensitive: irq_n=0 and i_flag=0.
REQ-025 Interrupt priority at the T1 decision SHALL be RST > NMI > IRQ.
REQ-026 At the T1 decision, activeInt SHALL be set to the winning code.
REQ-027 activeInt SHALL clear on the advance edge where last_cycle=1 for the forced BRK.
REQ-028 A new NMI arriving during an active IRQ sequence SHALL stay pending and be taken at the next T1.
REQ-029 When rdy=0 on an advance edge, T, OP, prevOP and nmi_pend SHALL hold.
REQ-030 Under REQ-029, phase SHALL keep toggling and a nmi_n edge SHALL still be captured.

Reset
REQ-031 While rst_n=0, outputs SHALL be: phase=0, T=T1, OP=prevOP=8'h00, activeInt=100, nmi_pend=0, seq_err=0, sync=1.
REQ-032 RST SHALL stay pending after rst_n rises, so the first T1 forces BRK with activeInt=100.
REQ-033 Reset asserted mid-instruction SHALL abort immediately to the REQ-031 state.

Configuration
REQ-034 Macro TSEQ_RDY_STALL_EN defined: rdy behaves per REQ-029 and REQ-030.
REQ-035 Macro TSEQ_RDY_STALL_EN undefined: rdy is ignored, the port remains and is unused, and sequencing never stalls.

Structure
REQ-036 Package cpu_seq_pkg SHALL hold the T0..T6 one-hot constants, the activeInt codes and the BRK opcode constant.
REQ-037 Submodule int_pending SHALL contain the NMI edge detector, the IRQ qualifier and the priority encode.
REQ-038 Submodule int_pending SHALL output a pending flag and its code.
REQ-039 Sequencer state, phase and opcode registers SHALL reside in the top module.

Verification
REQ-040 Release reset; opcode_in=8'hA9 -> first T1 loads OP=00 with activeInt=100; after last_cycle, next T1 loads OP=A9 and prevOP=00.
REQ-041 OP=A9 with last_cycle at T2 -> T sequence T1,T2,T1 and prevOP=A9 on return to T1; sync high only in T1.
REQ-042 irq_n=0, i_flag=1 -> OP loads opcode_in normally; set i_flag=0 -> next T1 gives OP=00 and activeInt=001.
REQ-043 nmi_n pulses low one cycle during T3 with irq_n=0 -> next T1 gives activeInt=010 (NMI wins); IRQ is taken after the BRK completes.
REQ-044 rdy=0 for 3 cycles in T3 (macro defined) -> T stays T3 for 3 extra cycles; with the macro undefined, T advances to T4.
REQ-045 last_cycle held 0 from T2 -> T reaches T6, holds, and seq_err=1 until reset.
